// File: rtl/post_neuron_updater_pkg.sv
// Shared types and constants for the post-neuron state updater.
// Default widths plus the signed saturation bounds for the default potential width.
package post_neuron_updater_pkg;

  localparam int unsigned PNU_ADDR_WIDTH   = 8;
  localparam int unsigned PNU_DATA_WIDTH   = 32;
  localparam int unsigned PNU_SRAM_DEPTH   = 256;
  localparam int unsigned PNU_WEIGHT_WIDTH = 8;

  localparam logic [PNU_DATA_WIDTH-1:0] PNU_SAT_MAX = {1'b0, {(PNU_DATA_WIDTH-1){1'b1}}};
  localparam logic [PNU_DATA_WIDTH-1:0] PNU_SAT_MIN = {1'b1, {(PNU_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_COMPUTE,
    ST_WRITE,
    ST_SPIKE,
    ST_CLEAR
  } pnu_state_t;

endpackage

// File: rtl/post_neuron_updater_if.sv
// Update-request, spike-event and SRAM bus signals of the post-neuron updater.
// master = updater side, slave = event pipeline / SRAM side.
interface post_neuron_updater_if #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WEIGHT_WIDTH = 8
);

  logic                    UPD_VALID;
  logic                    UPD_READY;
  logic [ADDR_WIDTH-1:0]   UPD_ADDR;
  logic [WEIGHT_WIDTH-1:0] UPD_WEIGHT;

  logic                    SPK_VALID;
  logic                    SPK_READY;
  logic [ADDR_WIDTH-1:0]   SPK_ADDR;

  logic                    SRAM_CS;
  logic                    SRAM_WE;
  logic [ADDR_WIDTH-1:0]   SRAM_A;
  logic [DATA_WIDTH-1:0]   SRAM_D;
  logic [DATA_WIDTH-1:0]   SRAM_Q;

  modport master (
    input  UPD_VALID, UPD_ADDR, UPD_WEIGHT, SPK_READY, SRAM_Q,
    output UPD_READY, SPK_VALID, SPK_ADDR, SRAM_CS, SRAM_WE, SRAM_A, SRAM_D
  );

  modport slave (
    output UPD_VALID, UPD_ADDR, UPD_WEIGHT, SPK_READY, SRAM_Q,
    input  UPD_READY, SPK_VALID, SPK_ADDR, SRAM_CS, SRAM_WE, SRAM_A, SRAM_D
  );

endinterface

// File: rtl/post_neuron_sat_add.sv
// Combinational membrane update: sign-extended weight added with saturation,
// then signed threshold compare; a firing neuron resets to zero.
module post_neuron_sat_add #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WEIGHT_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]   q_i,
  input  logic [WEIGHT_WIDTH-1:0] weight_i,
  input  logic [DATA_WIDTH-1:0]   threshold_i,
  output logic                    fire_o,
  output logic [DATA_WIDTH-1:0]   next_o
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0] sum;

  always_comb begin
    // One guard bit: overflow shows up as the two top bits disagreeing.
    wide = {q_i[DATA_WIDTH-1], q_i}
         + {{(DATA_WIDTH + 1 - WEIGHT_WIDTH){weight_i[WEIGHT_WIDTH-1]}}, weight_i};
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
      sum = wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = wide[DATA_WIDTH-1:0];
    end
    fire_o = ($signed(sum) >= $signed(threshold_i));
    next_o = fire_o ? '0 : sum;
  end

endmodule

// File: rtl/post_neuron_updater.sv
// Post-neuron state updater: serialized read-modify-write of membrane potentials
// in a 1-cycle-read SRAM, threshold firing with spike handshake, and a clear-all sweep.
module post_neuron_updater
  import post_neuron_updater_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = PNU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = PNU_DATA_WIDTH,
  parameter int unsigned SRAM_DEPTH   = PNU_SRAM_DEPTH,
  parameter int unsigned WEIGHT_WIDTH = PNU_WEIGHT_WIDTH
) (
  input  logic                  CK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] THRESHOLD,
  input  logic                  CLR_START,
  output logic                  CLR_DONE,
  output logic                  BUSY,
  post_neuron_updater_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(SRAM_DEPTH - 1);

  pnu_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
  logic                    fire_q, fire_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    rdy_en_q, rdy_en_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic                    spk_valid_q, spk_valid_d;
  logic [ADDR_WIDTH-1:0]   spk_addr_q, spk_addr_d;
  logic                    clr_done_q, clr_done_d;

  logic                    sat_fire;
  logic [DATA_WIDTH-1:0]   sat_next;
  logic                    upd_ready;

  post_neuron_sat_add #(
    .DATA_WIDTH   (DATA_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_sat_add (
    .q_i         (bus.SRAM_Q),
    .weight_i    (weight_q),
    .threshold_i (THRESHOLD),
    .fire_o      (sat_fire),
    .next_o      (sat_next)
  );

  // Ready stays low through reset and yields to a simultaneous clear request.
  assign upd_ready = rdy_en_q && (state_q == ST_IDLE) && !CLR_START;

  // SRAM strobes are computed from the next state so the pins come straight off flops.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    weight_d    = weight_q;
    fire_d      = fire_q;
    clr_cnt_d   = clr_cnt_q;
    rdy_en_d    = 1'b1;
    cs_d        = 1'b0;
    we_d        = 1'b0;
    a_d         = a_q;
    wd_d        = wd_q;
    spk_valid_d = 1'b0;
    spk_addr_d  = spk_addr_q;
    clr_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (CLR_START) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
          cs_d      = 1'b1;
          we_d      = 1'b1;
          a_d       = '0;
          wd_d      = '0;
        end else if (bus.UPD_VALID && upd_ready) begin
          state_d  = ST_READ;
          addr_d   = bus.UPD_ADDR;
          weight_d = bus.UPD_WEIGHT;
          cs_d     = 1'b1;
          a_d      = bus.UPD_ADDR;
        end
      end
      ST_READ: begin
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        state_d = ST_WRITE;
        fire_d  = sat_fire;
        cs_d    = 1'b1;
        we_d    = 1'b1;
        a_d     = addr_q;
        wd_d    = sat_next;
      end
      ST_WRITE: begin
        if (fire_q) begin
          state_d     = ST_SPIKE;
          spk_valid_d = 1'b1;
          spk_addr_d  = addr_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SPIKE: begin
        if (bus.SPK_READY) begin
          state_d = ST_IDLE;
        end else begin
          spk_valid_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          cs_d      = 1'b1;
          we_d      = 1'b1;
          a_d       = clr_cnt_q + 1'b1;
          wd_d      = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      weight_q    <= '0;
      fire_q      <= 1'b0;
      clr_cnt_q   <= '0;
      rdy_en_q    <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      a_q         <= '0;
      wd_q        <= '0;
      spk_valid_q <= 1'b0;
      spk_addr_q  <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      weight_q    <= weight_d;
      fire_q      <= fire_d;
      clr_cnt_q   <= clr_cnt_d;
      rdy_en_q    <= rdy_en_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      a_q         <= a_d;
      wd_q        <= wd_d;
      spk_valid_q <= spk_valid_d;
      spk_addr_q  <= spk_addr_d;
      clr_done_q  <= clr_done_d;
    end
  end

  assign bus.UPD_READY = upd_ready;
  assign bus.SPK_VALID = spk_valid_q;
  assign bus.SPK_ADDR  = spk_addr_q;
  assign bus.SRAM_CS   = cs_q;
  assign bus.SRAM_WE   = we_q;
  assign bus.SRAM_A    = a_q;
  assign bus.SRAM_D    = wd_q;
  assign CLR_DONE      = clr_done_q;
  assign BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_post_neuron_updater.sv
// Directed bench for post_neuron_updater with a behavioural 1-cycle-read SRAM
// and a write/spike scoreboard fed by a reference model of the membrane update.
module tb_post_neuron_updater;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] threshold;
  logic        clr_start;
  logic        clr_done;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int spk_seen    = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  wr_t         exp_wr  [$];
  logic [7:0]  exp_spk [$];
  wr_t         mon_e;
  logic [7:0]  mon_s;

  always #5 clk = ~clk;

  post_neuron_updater_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WEIGHT_WIDTH(8)) bus ();

  post_neuron_updater #(
    .ADDR_WIDTH   (8),
    .DATA_WIDTH   (32),
    .SRAM_DEPTH   (256),
    .WEIGHT_WIDTH (8)
  ) dut (
    .CK        (clk),
    .RST_N     (rst_n),
    .THRESHOLD (threshold),
    .CLR_START (clr_start),
    .CLR_DONE  (clr_done),
    .BUSY      (busy),
    .bus       (bus.master)
  );

  // SRAM model: registered read, Q holds while CS is low
  always @(posedge clk) begin
    if (bus.SRAM_CS) begin
      if (bus.SRAM_WE) mem[bus.SRAM_A] <= bus.SRAM_D;
      else             bus.SRAM_Q <= mem[bus.SRAM_A];
    end
  end

  always @(negedge clk) begin
    if (bus.SRAM_CS && bus.SRAM_WE) begin
      vectors++;
      assert (exp_wr.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_write observed a=%0d d=%h expected no write", bus.SRAM_A, bus.SRAM_D);
      end
      if (exp_wr.size() > 0) begin
        mon_e = exp_wr.pop_front();
        vectors++;
        assert ({bus.SRAM_A, bus.SRAM_D} === {mon_e.a, mon_e.d}) else begin
          miscompares++;
          $error("FAIL sram_write observed a=%0d d=%h expected a=%0d d=%h",
                 bus.SRAM_A, bus.SRAM_D, mon_e.a, mon_e.d);
        end
      end
    end
    if (bus.SPK_VALID && bus.SPK_READY) begin
      spk_seen++;
      vectors++;
      assert (exp_spk.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_spike observed addr=%0d expected no spike", bus.SPK_ADDR);
      end
      if (exp_spk.size() > 0) begin
        mon_s = exp_spk.pop_front();
        vectors++;
        assert (bus.SPK_ADDR === mon_s) else begin
          miscompares++;
          $error("FAIL spike_addr observed=%0d expected=%0d", bus.SPK_ADDR, mon_s);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [7:0] w,
                                             input logic [31:0] thr, output logic fire);
    longint s;
    s = longint'($signed(cur)) + longint'($signed(w));
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    fire = (s >= longint'($signed(thr)));
    return fire ? 32'd0 : s[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear();
    for (int i = 0; i < 256; i++) begin
      exp_wr.push_back('{a: 8'(i), d: 32'd0});
      ref_mem[i] = 32'd0;
    end
  endtask

  task automatic push_update(input logic [7:0] a, input logic [7:0] w);
    logic [31:0] nxt;
    logic        f;
    nxt = model_next(ref_mem[a], w, threshold, f);
    ref_mem[a] = nxt;
    exp_wr.push_back('{a: a, d: nxt});
    if (f) exp_spk.push_back(a);
  endtask

  // Leaves the bench 1 time unit after the accepting edge.
  task automatic accept_update(input logic [7:0] a, input logic [7:0] w, input bit model);
    int n = 0;
    bus.UPD_VALID  = 1'b1;
    bus.UPD_ADDR   = a;
    bus.UPD_WEIGHT = w;
    while (!bus.UPD_READY && n < 50) begin
      tick();
      n++;
    end
    check("upd_ready_timeout", 64'(n < 50), 64'd1);
    if (model) push_update(a, w);
    tick();
    bus.UPD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_n);
    int n = 0;
    while (busy && n < 600) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp_n));
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    threshold      = 32'd100;
    clr_start      = 1'b0;
    bus.UPD_VALID  = 1'b0;
    bus.UPD_ADDR   = '0;
    bus.UPD_WEIGHT = '0;
    bus.SPK_READY  = 1'b1;
    bus.SRAM_Q    <= '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= $urandom();
      ref_mem[i]  = 32'd0;
    end

    #12;
    check("rst_upd_ready", 64'(bus.UPD_READY), 64'd0);
    check("rst_sram_cs",   64'(bus.SRAM_CS),   64'd0);
    check("rst_sram_we",   64'(bus.SRAM_WE),   64'd0);
    check("rst_sram_a",    64'(bus.SRAM_A),    64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    check("rst_clr_done",  64'(clr_done),      64'd0);
    check("rst_spk_valid", 64'(bus.SPK_VALID), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_upd_ready", 64'(bus.UPD_READY), 64'd1);

    // Clear sweep: 256 zero writes, done one cycle after the last
    clr_start = 1'b1;
    push_clear();
    tick();
    clr_start = 1'b0;
    check("clr_busy", 64'(busy), 64'd1);
    n = 0;
    while (!clr_done && n < 400) begin
      tick();
      n++;
    end
    check("clr_done_cycles", 64'(n), 64'd256);
    check("clr_done_busy", 64'(busy), 64'd0);
    tick();
    check("clr_done_pulse", 64'(clr_done), 64'd0);
    check("clr_writes_drained", 64'(exp_wr.size()), 64'd0);

    // Accumulate to threshold at address 5
    accept_update(8'd5, 8'd40, 1'b1);
    wait_idle("lat_nofire_1", 3);
    accept_update(8'd5, 8'd40, 1'b1);
    wait_idle("lat_nofire_2", 3);
    check("mem5_80", 64'(mem[5]), 64'd80);
    check("no_spike_yet", 64'(spk_seen), 64'd0);
    accept_update(8'd5, 8'd40, 1'b1);
    wait_idle("lat_fire", 4);
    check("mem5_fired", 64'(mem[5]), 64'd0);
    check("spike_count_1", 64'(spk_seen), 64'd1);

    // Positive saturation fires at the maximum threshold
    threshold   = 32'h7FFF_FFFF;
    mem[7]     <= 32'h7FFF_FFF0;
    ref_mem[7]  = 32'h7FFF_FFF0;
    accept_update(8'd7, 8'd127, 1'b1);
    wait_idle("lat_sat_pos", 4);
    check("mem7_sat_fire", 64'(mem[7]), 64'd0);
    // Negative saturation clamps without firing
    mem[9]     <= 32'h8000_0005;
    ref_mem[9]  = 32'h8000_0005;
    accept_update(8'd9, 8'h80, 1'b1);
    wait_idle("lat_sat_neg", 3);
    check("mem9_sat_min", 64'(mem[9]), 64'h8000_0000);
    check("spike_count_2", 64'(spk_seen), 64'd2);
    threshold = 32'd100;

    // Spike backpressure
    bus.SPK_READY = 1'b0;
    mem[3]     <= 32'd90;
    ref_mem[3]  = 32'd90;
    accept_update(8'd3, 8'd20, 1'b1);
    n = 0;
    while (!bus.SPK_VALID && n < 10) begin
      tick();
      n++;
    end
    check("spk_valid_cycles", 64'(n), 64'd3);
    for (int i = 0; i < 10; i++) begin
      check("bp_spk_valid", 64'(bus.SPK_VALID), 64'd1);
      check("bp_spk_addr",  64'(bus.SPK_ADDR),  64'd3);
      check("bp_upd_ready", 64'(bus.UPD_READY), 64'd0);
      tick();
    end
    bus.SPK_READY = 1'b1;
    tick();
    check("bp_release_valid", 64'(bus.SPK_VALID), 64'd0);
    check("bp_release_busy",  64'(busy),          64'd0);
    check("mem3_fired", 64'(mem[3]), 64'd0);
    check("spike_count_3", 64'(spk_seen), 64'd3);

    // Clear has priority over a simultaneous update
    clr_start      = 1'b1;
    bus.UPD_VALID  = 1'b1;
    bus.UPD_ADDR   = 8'd5;
    bus.UPD_WEIGHT = 8'd10;
    #1;
    check("clr_prio_ready", 64'(bus.UPD_READY), 64'd0);
    push_clear();
    push_update(8'd5, 8'd10);
    tick();
    clr_start = 1'b0;
    n = 0;
    while (!clr_done && n < 400) begin
      tick();
      n++;
    end
    check("clr2_done_cycles", 64'(n), 64'd256);
    check("clr2_ready_after", 64'(bus.UPD_READY), 64'd1);
    tick();
    bus.UPD_VALID = 1'b0;
    wait_idle("lat_after_clear", 3);
    check("mem5_after_clear", 64'(mem[5]), 64'd10);
    check("clr2_writes_drained", 64'(exp_wr.size()), 64'd0);

    // Reset while COMPUTE is pending a write
    mem[11] <= 32'd50;
    accept_update(8'd11, 8'd5, 1'b0);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_cs",        64'(bus.SRAM_CS),   64'd0);
    check("midrst_we",        64'(bus.SRAM_WE),   64'd0);
    check("midrst_busy",      64'(busy),          64'd0);
    check("midrst_upd_ready", 64'(bus.UPD_READY), 64'd0);
    check("midrst_spk_valid", 64'(bus.SPK_VALID), 64'd0);
    repeat (3) tick();
    check("midrst_mem11", 64'(mem[11]), 64'd50);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("midrst_recover_ready", 64'(bus.UPD_READY), 64'd1);
    check("final_wr_queue",  64'(exp_wr.size()),  64'd0);
    check("final_spk_queue", 64'(exp_spk.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
